trng_word_collector: RTL and testbench

- Downstream consumer of the TRNG core's `random_bit` stream.
- Samples the raw bit stream and applies von Neumann debiasing to remove bias.
- Packs the debiased bits into WORD_BITS-wide words and buffers them in a small FIFO.
- The RISC-V pipeline's memory-mapped TRNG data register pops words from the FIFO with a simple read handshake.

---
 rtl/trng_word_collector.sv | 216 +++++++++++++++++++++
 tb/tb_trng_word_collector.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_word_collector.sv
// trng_word_collector
//   Von Neumann debiases the raw TRNG bit stream, packs the surviving bits
//   into WORD_BITS-wide words and buffers them in a FIFO_DEPTH-entry FIFO
//   that the CPU pops through a one-cycle-latency read handshake.
//
//   Optional feature (macro TRNG_HEALTH_EN): repetition-count health test on
//   the raw samples. A run of RCT_CUTOFF identical samples sets the sticky
//   health_fail flag, flushes the FIFO and the partial word, and stops
//   collection until clr_fail is pulsed. Without the macro health_fail is 0
//   and clr_fail is ignored.
//
// Ports
//   clk         clock
//   rstn        synchronous active-low reset
//   raw_bit     raw entropy bit from the TRNG core
//   raw_valid   raw_bit is a fresh sample this cycle
//   rd_en       pop request
//   rd_data     popped word (registered, holds between pops)
//   rd_valid    one-cycle pulse, rd_data is valid
//   empty       FIFO holds no words (registered)
//   full        FIFO holds FIFO_DEPTH words (registered)
//   health_fail sticky repetition-count failure
//   clr_fail    clears health_fail and restarts collection
module trng_word_collector #(
  parameter int unsigned WORD_BITS  = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RCT_CUTOFF = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 raw_bit,
  input  logic                 raw_valid,
  input  logic                 rd_en,
  output logic [WORD_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 health_fail,
  input  logic                 clr_fail
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(WORD_BITS);

  typedef enum logic {
    IDLE,
    HAVE_FIRST
  } pair_state_t;

  pair_state_t state_q, state_d;
  logic                 first_q;
  logic                 emit_c;

  logic [WORD_BITS-1:0] shift_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [WORD_BITS-1:0] hold_q;
  logic                 hold_valid_q;

  logic [WORD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 empty_q, full_q;
  logic                 push_c, pop_c;

  logic                 fail_q;
  logic                 trip_c;
  logic                 block_c;

  // Collection and pops stop while failed and in the cycle the test trips.
  assign block_c = fail_q | trip_c;

`ifdef TRNG_HEALTH_EN
  localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);

  logic [RCT_W-1:0] rct_cnt_q;
  logic             prev_q;

  assign trip_c = !fail_q && (rct_cnt_q == RCT_W'(RCT_CUTOFF));

  // Repetition-count test; the counter saturates at the cutoff and freezes
  // while failed so the flag stays meaningful until cleared.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fail_q    <= 1'b0;
      rct_cnt_q <= '0;
      prev_q    <= 1'b0;
    end else if (clr_fail) begin
      fail_q    <= 1'b0;
      rct_cnt_q <= '0;
    end else begin
      if (trip_c) fail_q <= 1'b1;
      if (!fail_q && raw_valid) begin
        prev_q <= raw_bit;
        if (rct_cnt_q == '0 || raw_bit != prev_q)
          rct_cnt_q <= RCT_W'(1);
        else if (rct_cnt_q != RCT_W'(RCT_CUTOFF))
          rct_cnt_q <= rct_cnt_q + RCT_W'(1);
      end
    end
  end
`else
  logic unused_cfg;

  assign fail_q     = 1'b0;
  assign trip_c     = 1'b0;
  assign unused_cfg = ^{clr_fail, 32'(RCT_CUTOFF)};
`endif

  assign health_fail = fail_q;

  // Pair FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pair FSM next state; a differing pair emits its first bit.
  always_comb begin
    state_d = state_q;
    emit_c  = 1'b0;
    if (block_c) begin
      state_d = IDLE;
    end else if (raw_valid) begin
      case (state_q)
        IDLE:       state_d = HAVE_FIRST;
        HAVE_FIRST: begin
          emit_c  = (raw_bit != first_q);
          state_d = IDLE;
        end
        default:    state_d = IDLE;
      endcase
    end
  end

  // First sample of the current pair.
  always_ff @(posedge clk) begin
    if (!rstn)
      first_q <= 1'b0;
    else if (raw_valid && state_q == IDLE && !block_c)
      first_q <= raw_bit;
  end

  assign push_c = hold_valid_q && !full_q && !block_c;
  assign pop_c  = rd_en && !empty_q && !block_c;

  // Word assembly; a finished word waits in hold_q until the FIFO accepts it
  // and any bits emitted meanwhile are dropped.
  always_ff @(posedge clk) begin
    if (!rstn || block_c) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      if (push_c) hold_valid_q <= 1'b0;
      if (emit_c && (!hold_valid_q || push_c)) begin
        shift_q <= {shift_q[WORD_BITS-2:0], first_q};
        if (bit_cnt_q == BIT_W'(WORD_BITS - 1)) begin
          hold_q       <= {shift_q[WORD_BITS-2:0], first_q};
          hold_valid_q <= 1'b1;
          bit_cnt_q    <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + BIT_W'(1);
        end
      end
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= hold_q;
  end

  // FIFO pointers, count and registered status flags.
  always_ff @(posedge clk) begin
    if (!rstn || block_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  // Read port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_c;
      if (pop_c) rd_data <= mem[rd_ptr_q];
    end
  end

  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: tb/tb_trng_word_collector.sv
// Testbench for trng_word_collector (default parameters). The reference model
// keeps every raw sample since the last reset/flush, forms the debiased bit
// list pairwise and slices it into 32-bit words, first bit at the MSB.
module tb_trng_word_collector;

  logic        clk;
  logic        rstn;
  logic        raw_bit;
  logic        raw_valid;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic        health_fail;
  logic        clr_fail;

  int passed;
  int total;
  int failed;

  bit          samp_q[$];
  bit          bit_q[$];
  int          popped;
  logic [31:0] last_rd;
  bit          last_samp;
  int          run_len;

  trng_word_collector dut (
    .clk        (clk),
    .rstn       (rstn),
    .raw_bit    (raw_bit),
    .raw_valid  (raw_valid),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .health_fail(health_fail),
    .clr_fail   (clr_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    samp_q.delete();
    bit_q.delete();
    popped = 0;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 32; j++) w[31-j] = bit_q[32*k + j];
    return w;
  endfunction

  function automatic int words_avail();
    return bit_q.size() / 32;
  endfunction

  task automatic send(input bit b);
    int n;
    raw_bit   = b;
    raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
    if (b == last_samp) run_len++;
    else                run_len = 1;
    last_samp = b;
    samp_q.push_back(b);
    n = samp_q.size();
    if (n % 2 == 0 && samp_q[n-2] != samp_q[n-1]) bit_q.push_back(samp_q[n-2]);
  endtask

  // Random sample, with runs capped so the health test cannot trip.
  task automatic send_rand();
    bit b;
    b = 1'($urandom_range(0, 1));
    if (run_len >= 8 && b == last_samp) b = ~b;
    send(b);
  endtask

  // Each bit b is sent as pair (b, ~b), so the emitted word equals w.
  task automatic send_word(input logic [31:0] w);
    for (int j = 31; j >= 0; j--) begin
      send(w[j]);
      send(~w[j]);
    end
  endtask

  task automatic read_expect(input string tag);
    logic [31:0] e;
    e = exp_word(popped);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk1({tag, "_valid"}, rd_valid, 1'b1);
    chk32({tag, "_data"}, rd_data, e);
    popped++;
    last_rd = e;
    tick();
    chk1({tag, "_pulse"}, rd_valid, 1'b0);
  endtask

  task automatic read_none(input string tag);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk1({tag, "_novalid"}, rd_valid, 1'b0);
    chk32({tag, "_hold"}, rd_data, last_rd);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    model_reset();
    last_rd = '0;
    run_len = 0;
  endtask

  initial begin
    logic [31:0] w [5];
    logic [31:0] wr;
    passed    = 0;
    total     = 0;
    failed    = 0;
    rstn      = 1'b0;
    raw_bit   = 1'b0;
    raw_valid = 1'b0;
    rd_en     = 1'b0;
    clr_fail  = 1'b0;
    last_samp = 1'b0;
    run_len   = 0;

    // Reset state
    do_reset();
    chk32("rst_rd_data", rd_data, 32'h0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk1("rst_health", health_fail, 1'b0);

    // 32 pairs of "10" -> all-ones word
    for (int i = 0; i < 64; i++) send(i % 2 == 0);
    chk1("ones_empty_pre", empty, 1'b1);
    tick();
    chk1("ones_empty_post", empty, 1'b0);
    chk1("ones_full", full, 1'b0);
    read_expect("ones");
    chk32("ones_const", rd_data, 32'hFFFF_FFFF);
    chk1("ones_empty_after", empty, 1'b1);

    // Pairs 01,10 repeated -> 0x55555555
    for (int i = 0; i < 16; i++) begin
      send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    end
    tick();
    tick();
    read_expect("alt");
    chk32("alt_const", rd_data, 32'h5555_5555);

    // Only 00 / 11 pairs -> nothing collected
    for (int i = 0; i < 50; i++) begin
      send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    end
    tick();
    chk1("same_empty", empty, 1'b1);
    read_none("same");
    chk1("same_health", health_fail, 1'b0);

    // Five words with no reads: fifth is held until a pop frees space
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      send_word(w[i]);
      if (i == 3) begin
        tick();
        chk1("fill4_full", full, 1'b1);
      end
    end
    tick();
    tick();
    chk1("fill5_full", full, 1'b1);
    chk1("fill5_empty", empty, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk1("fill_pop_valid", rd_valid, 1'b1);
    chk32("fill_pop_data", rd_data, w[0]);
    chk1("fill_pop_full", full, 1'b0);
    popped++;
    last_rd = w[0];
    tick();
    chk1("fill_refull", full, 1'b1);
    chk1("fill_pulse", rd_valid, 1'b0);
    for (int i = 1; i < 5; i++) begin
      read_expect("fill_drain");
      chk32("fill_order", rd_data, w[i]);
    end
    chk1("fill_empty", empty, 1'b1);

    // Reset mid-word with two words buffered
    send_word($urandom);
    send_word($urandom);
    for (int j = 0; j < 20; j++) begin
      wr[0] = 1'($urandom_range(0, 1));
      send(wr[0]);
      send(~wr[0]);
    end
    tick();
    tick();
    chk1("mid_empty_pre", empty, 1'b0);
    do_reset();
    chk1("mid_rst_empty", empty, 1'b1);
    chk1("mid_rst_full", full, 1'b0);
    chk1("mid_rst_valid", rd_valid, 1'b0);
    chk32("mid_rst_data", rd_data, 32'h0);
    wr = $urandom;
    send_word(wr);
    tick();
    tick();
    read_expect("mid_fresh");
    chk32("mid_fresh_const", rd_data, wr);

    // Randomized traffic with idle gaps, checked against the model
    for (int batch = 0; batch < 6; batch++) begin
      while (words_avail() < popped + 3) begin
        repeat ($urandom_range(0, 2)) tick();
        send_rand();
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(0, 3)) tick();
        read_expect("rand");
      end
      chk1("rand_empty", empty, 1'b1);
    end
    read_none("rand_end");

`ifdef TRNG_HEALTH_EN
    // 16 identical raw samples trip the health test
    do_reset();
    send_word($urandom);
    send(1'b0);
    for (int i = 0; i < 16; i++) send(1'b1);
    chk1("hf_pre", health_fail, 1'b0);
    chk1("hf_pre_empty", empty, 1'b0);
    tick();
    chk1("hf_set", health_fail, 1'b1);
    chk1("hf_empty", empty, 1'b1);
    chk1("hf_full", full, 1'b0);
    read_none("hf_read");
    for (int i = 0; i < 8; i++) send(i % 2 == 0);
    chk1("hf_sticky", health_fail, 1'b1);
    clr_fail = 1'b1;
    tick();
    clr_fail = 1'b0;
    chk1("hf_clear", health_fail, 1'b0);
    chk1("hf_clear_empty", empty, 1'b1);
    model_reset();
    run_len = 0;
    wr = $urandom;
    send_word(wr);
    tick();
    tick();
    read_expect("hf_resume");
    chk32("hf_resume_const", rd_data, wr);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
